// File: rtl/qdr_sram_pkg.sv
// Shared types and limits for the QDR SRAM responder model.
package qdr_sram_pkg;

    typedef enum logic [1:0] {
        DLL_OFF = 2'd0,
        LOCKING = 2'd1,
        READY   = 2'd2
    } qdr_state_e;

    localparam int unsigned CNT_WIDTH      = 16;
    localparam int unsigned MAX_RD_LATENCY = 7;

endpackage

// File: rtl/qdr_sram_rd_pipe.sv
// Read-data delay line: valid + data shift register with synchronous flush.
// Data is forced to zero in any stage that does not hold a valid read.
module qdr_sram_rd_pipe #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/qdr_sram_responder.sv
// Behavioural QDR SRAM device: DLL lock sequencing, word array, fixed-latency reads.
// Define QDR_SRAM_WR_BYPASS_EN to return same-cycle write data to a colliding read.
module qdr_sram_responder
    import qdr_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 36,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned RD_LATENCY  = 3,
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] qdr_sa,
    input  logic                  qdr_w_n,
    input  logic                  qdr_r_n,
    input  logic [DATA_WIDTH-1:0] qdr_d_rise,
    input  logic [DATA_WIDTH-1:0] qdr_d_fall,
    input  logic                  qdr_dll_off_n,
    output logic [DATA_WIDTH-1:0] qdr_q_rise,
    output logic [DATA_WIDTH-1:0] qdr_q_fall,
    output logic                  qdr_qvld,
    output logic                  ready,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int unsigned WORD_W     = 2 * DATA_WIDTH;
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
    localparam int unsigned LOCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int unsigned PIPE_DEPTH = (RD_LATENCY < 1) ? 1 :
                                         (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                                         RD_LATENCY;

    qdr_state_e        state;
    logic [LOCK_W-1:0] lock_cnt;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              wr_acc;
    logic              rd_acc;
    logic              pipe_flush;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] q_word;

    // Reset outranks any command presented in the same cycle.
    assign wr_acc     = !reset && (state == READY) && !qdr_w_n;
    assign rd_acc     = !reset && (state == READY) && !qdr_r_n;
    assign pipe_flush = (state == READY) && !qdr_dll_off_n;
    assign wr_word    = {qdr_d_fall, qdr_d_rise};

    // Lock sequencer; dropping qdr_dll_off_n forces DLL_OFF from any state.
    always_ff @(posedge clk) begin
        if (reset || !qdr_dll_off_n) begin
            state    <= DLL_OFF;
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                DLL_OFF: begin
                    state    <= LOCKING;
                    lock_cnt <= '0;
                end
                LOCKING: begin
                    if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                READY: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= DLL_OFF;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[qdr_sa] <= wr_word;
        end
    end

`ifdef QDR_SRAM_WR_BYPASS_EN
    assign rd_word = wr_acc ? wr_word : mem[qdr_sa];
`else
    assign rd_word = mem[qdr_sa];
`endif

    // Accepted-command counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_acc && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
            if (rd_acc && (rd_count != '1)) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    qdr_sram_rd_pipe #(
        .WIDTH (WORD_W),
        .DEPTH (PIPE_DEPTH)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (pipe_flush),
        .in_valid  (rd_acc),
        .in_data   (rd_word),
        .out_valid (qdr_qvld),
        .out_data  (q_word)
    );

    assign qdr_q_rise = q_word[DATA_WIDTH-1:0];
    assign qdr_q_fall = q_word[WORD_W-1:DATA_WIDTH];

endmodule

// File: tb/tb_qdr_sram_responder.sv
// Scoreboard bench for qdr_sram_responder: directed lock, read/write, stream,
// collision, drop and counter saturation scenarios.
module tb_qdr_sram_responder;

    localparam int unsigned DW = 36;
    localparam int unsigned AW = 10;
    localparam int unsigned RL = 3;
    localparam int unsigned LC = 64;

    typedef struct {
        int unsigned   cyc;
        logic [DW-1:0] r;
        logic [DW-1:0] f;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] qdr_sa;
    logic          qdr_w_n;
    logic          qdr_r_n;
    logic [DW-1:0] qdr_d_rise;
    logic [DW-1:0] qdr_d_fall;
    logic          qdr_dll_off_n;
    logic [DW-1:0] qdr_q_rise;
    logic [DW-1:0] qdr_q_fall;
    logic          qdr_qvld;
    logic          ready;
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;

    int unsigned cyc;
    int          total;
    int          bad;
    exp_t        sb[$];

    qdr_sram_responder #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .RD_LATENCY  (RL),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .qdr_sa        (qdr_sa),
        .qdr_w_n       (qdr_w_n),
        .qdr_r_n       (qdr_r_n),
        .qdr_d_rise    (qdr_d_rise),
        .qdr_d_fall    (qdr_d_fall),
        .qdr_dll_off_n (qdr_dll_off_n),
        .qdr_q_rise    (qdr_q_rise),
        .qdr_q_fall    (qdr_q_fall),
        .qdr_qvld      (qdr_qvld),
        .ready         (ready),
        .wr_count      (wr_count),
        .rd_count      (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every valid beat must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (qdr_qvld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_qvld", 72'(1), 72'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("qvld_cycle", 72'(cyc), 72'(e.cyc));
                    chk("q_rise", 72'(qdr_q_rise), 72'(e.r));
                    chk("q_fall", 72'(qdr_q_fall), 72'(e.f));
                end
            end else begin
                chk("q_idle_zero", 72'({qdr_q_fall, qdr_q_rise}), 72'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) tick();
    endtask

    // Present one command for exactly one cycle.
    task automatic drive(input logic wr, input logic rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] r, input logic [DW-1:0] f);
        qdr_w_n    = !wr;
        qdr_r_n    = !rd;
        qdr_sa     = a;
        qdr_d_rise = r;
        qdr_d_fall = f;
        tick();
        qdr_w_n = 1'b1;
        qdr_r_n = 1'b1;
    endtask

    task automatic expect_read(input logic [DW-1:0] r, input logic [DW-1:0] f);
        exp_t e;
        e.cyc = cyc + RL;
        e.r   = r;
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 72'(sb.size()), 72'(0));
        repeat (RL + 2) tick();
    endtask

    task automatic relock();
        int n = 0;
        qdr_dll_off_n = 1'b1;
        while (!ready && n < LC + 20) begin
            tick();
            n++;
        end
        chk("relock_ready", 72'(ready), 72'(1));
    endtask

    int unsigned c0;
    int unsigned t;
    logic [DW-1:0] coll_exp;

    initial begin
        total = 0;
        bad   = 0;
        reset         = 1'b1;
        qdr_sa        = '0;
        qdr_w_n       = 1'b1;
        qdr_r_n       = 1'b1;
        qdr_d_rise    = '0;
        qdr_d_fall    = '0;
        qdr_dll_off_n = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 72'(ready), 72'(0));
        chk("rst_qvld", 72'(qdr_qvld), 72'(0));
        chk("rst_q", 72'({qdr_q_fall, qdr_q_rise}), 72'(0));
        chk("rst_wr_count", 72'(wr_count), 72'(0));
        chk("rst_rd_count", 72'(rd_count), 72'(0));

        // Lock sequence; a read during LOCKING is dropped.
        reset         = 1'b0;
        qdr_dll_off_n = 1'b1;
        c0 = cyc;
        wait_until(c0 + 10);
        drive(1'b0, 1'b1, 10'h005, '0, '0);
        wait_until(c0 + LC);
        chk("ready_before_lock", 72'(ready), 72'(0));
        wait_until(c0 + LC + 1);
        chk("ready_at_lock", 72'(ready), 72'(1));
        chk("locking_rd_dropped", 72'(rd_count), 72'(0));

        // Single write then read of the same word.
        drive(1'b1, 1'b0, 10'h005, 36'h123456789, 36'hABCDEF012);
        expect_read(36'h123456789, 36'hABCDEF012);
        drive(1'b0, 1'b1, 10'h005, '0, '0);
        drain();
        chk("wr_count_1", 72'(wr_count), 72'(1));
        chk("rd_count_1", 72'(rd_count), 72'(1));

        // Stream of back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, AW'(i), DW'(36'h100 + i), DW'(36'hF00 + i));
        end
        for (int i = 0; i < 16; i++) begin
            expect_read(DW'(36'h100 + i), DW'(36'hF00 + i));
            drive(1'b0, 1'b1, AW'(i), '0, '0);
        end
        drain();
        chk("wr_count_17", 72'(wr_count), 72'(17));
        chk("rd_count_17", 72'(rd_count), 72'(17));

        // Same-cycle read/write collision at 0x020.
        drive(1'b1, 1'b0, 10'h020, 36'hAAAA0000A, 36'hAAAA1111A);
`ifdef QDR_SRAM_WR_BYPASS_EN
        coll_exp = 36'hBBBB0000B;
        expect_read(36'hBBBB0000B, 36'hBBBB1111B);
`else
        coll_exp = 36'hAAAA0000A;
        expect_read(36'hAAAA0000A, 36'hAAAA1111A);
`endif
        drive(1'b1, 1'b1, 10'h020, 36'hBBBB0000B, 36'hBBBB1111B);
        drain();
        expect_read(36'hBBBB0000B, 36'hBBBB1111B);
        drive(1'b0, 1'b1, 10'h020, '0, '0);
        drain();
        chk("wr_count_19", 72'(wr_count), 72'(19));
        chk("rd_count_19", 72'(rd_count), 72'(19));

        // Drop: DLL goes off one cycle after a read; no qvld may follow.
        drive(1'b1, 1'b0, 10'h030, 36'h0C0C0C0C0, 36'h0D0D0D0D0);
        t = cyc;
        drive(1'b0, 1'b1, 10'h030, '0, '0);
        qdr_dll_off_n = 1'b0;
        tick();
        chk("drop_ready_off", 72'(ready), 72'(0));
        drive(1'b1, 1'b0, 10'h030, 36'hFFFFFFFFF, 36'hFFFFFFFFF);
        repeat (RL + 3) tick();
        chk("drop_no_pending", 72'(sb.size()), 72'(0));
        chk("drop_wr_count", 72'(wr_count), 72'(20));
        chk("drop_rd_count", 72'(rd_count), 72'(20));
        relock();
        expect_read(36'h0C0C0C0C0, 36'h0D0D0D0D0);
        drive(1'b0, 1'b1, 10'h030, '0, '0);
        drain();
        chk("post_relock_rd_count", 72'(rd_count), 72'(21));

        // Saturation: 65540 accepted writes on top of the 20 already counted.
        qdr_sa     = 10'h3FF;
        qdr_d_rise = 36'h5A5A5A5A5;
        qdr_d_fall = 36'hA5A5A5A5A;
        qdr_w_n    = 1'b0;
        repeat (65514) tick();
        chk("sat_minus_one", 72'(wr_count), 72'(16'hFFFE));
        tick();
        chk("sat_reached", 72'(wr_count), 72'(16'hFFFF));
        repeat (65540 - 65515) tick();
        qdr_w_n = 1'b1;
        tick();
        chk("sat_no_wrap", 72'(wr_count), 72'(16'hFFFF));
        chk("sat_rd_untouched", 72'(rd_count), 72'(21));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
